// File: rtl/dt1_hazunit_mc.sv
// Hazard unit for the 5-stage RV32I core: forwarding, branch flush, load-use and mul/div stalls.
// Optional stall/flush performance counters are enabled with `HAZ_PERF_EN.
module dt1_hazunit_mc #(
  parameter int RAW      = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] Rs1E,
  input  logic [RAW-1:0] Rs2E,
  input  logic [RAW-1:0] RdE,
  input  logic [RAW-1:0] RdM,
  input  logic [RAW-1:0] RdW,
  input  logic           RegWriteE,
  input  logic           RegWriteM,
  input  logic           RegWriteW,
  input  logic [RAW-1:0] Rs1D,
  input  logic [RAW-1:0] Rs2D,
  input  logic           ResultSrcEb0,
  input  logic           MdStartE,
  input  logic           PCSrcE,
  output logic [1:0]     ForwardAE,
  output logic [1:0]     ForwardBE,
  output logic           StallF,
  output logic           StallD,
  output logic           StallE,
  output logic           FlushD,
  output logic           FlushE,
  output logic           FlushM,
  output logic           MdBusy
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
`endif
);

  localparam int MaxLat = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CntW   = $clog2(MaxLat) + 1;
  localparam logic [CntW-1:0] LdInit = CntW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  // The IDLE cycle that launches a mul/div is already a stall cycle, so MDBUSY
  // lasts MD_LAT-2 cycles and the counter starts one below that.
  localparam logic [CntW-1:0] MdInit = CntW'((MD_LAT > 2) ? MD_LAT - 3 : 0);

  typedef enum logic [1:0] {IDLE, LSTALL, MDBUSY} state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            mdRelease, mdReleaseNext;
  logic            lu, ldStall, mdStall;

  always_comb begin
    ForwardAE = 2'b00;
    if (Rs1E != '0 && RegWriteM && Rs1E == RdM)      ForwardAE = 2'b10;
    else if (Rs1E != '0 && RegWriteW && Rs1E == RdW) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (Rs2E != '0 && RegWriteM && Rs2E == RdM)      ForwardBE = 2'b10;
    else if (Rs2E != '0 && RegWriteW && Rs2E == RdW) ForwardBE = 2'b01;
  end

  assign lu = ResultSrcEb0 & RegWriteE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE)) & ~PCSrcE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mdRelease <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      mdRelease <= mdReleaseNext;
    end
  end

  // mdRelease marks the cycle after the last mul/div stall: the op is still in E
  // with MdStartE high and must leave rather than relaunch.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    mdReleaseNext = 1'b0;
    ldStall       = 1'b0;
    mdStall       = 1'b0;
    case (state)
      IDLE: begin
        if (MdStartE && !mdRelease && MD_LAT > 1) begin
          mdStall = 1'b1;
          if (MD_LAT > 2) begin
            stateNext = MDBUSY;
            cntNext   = MdInit;
          end else begin
            mdReleaseNext = 1'b1;
          end
        end else if (lu) begin
          ldStall = 1'b1;
          if (LOAD_LAT > 1) begin
            stateNext = LSTALL;
            cntNext   = LdInit;
          end
        end
      end
      LSTALL: begin
        ldStall = 1'b1;
        if (cnt == '0) stateNext = IDLE;
        else           cntNext   = cnt - CntW'(1);
      end
      MDBUSY: begin
        mdStall = 1'b1;
        if (cnt == '0) begin
          stateNext     = IDLE;
          mdReleaseNext = 1'b1;
        end else begin
          cntNext = cnt - CntW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reset masks the controls combinationally so an abort takes effect in-cycle.
  assign StallF = (ldStall | mdStall) & ~reset;
  assign StallD = (ldStall | mdStall) & ~reset;
  assign StallE = mdStall & ~reset;
  assign FlushM = mdStall & ~reset;
  assign FlushD = PCSrcE & ~reset;
  assign FlushE = (PCSrcE | ldStall) & ~mdStall & ~reset;
  assign MdBusy = (state != IDLE);

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (StallD && StallCycles != '1)             StallCycles <= StallCycles + CNT_W'(1);
      if ((FlushD || FlushE) && FlushCycles != '1) FlushCycles <= FlushCycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dt1_hazunit_mc.sv
// Directed self-checking bench for dt1_hazunit_mc (LOAD_LAT=1 and LOAD_LAT=3 instances, MD_LAT=4).
// Control vectors are {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}.
module tb_dt1_hazunit_mc;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW, Rs1D, Rs2D;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, MdStartE, PCSrcE;
  wire  [1:0] aFA, aFB, bFA, bFB;
  wire  [6:0] aCtl, bCtl;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dt1_hazunit_mc #(.RAW(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(32)) dA (
    .clk(clk), .reset(reset), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ResultSrcEb0(ResultSrcEb0), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .ForwardAE(aFA), .ForwardBE(aFB), .StallF(aCtl[6]), .StallD(aCtl[5]), .StallE(aCtl[4]),
    .FlushD(aCtl[3]), .FlushE(aCtl[2]), .FlushM(aCtl[1]), .MdBusy(aCtl[0])
`ifdef HAZ_PERF_EN
    , .StallCycles(), .FlushCycles()
`endif
  );

  dt1_hazunit_mc #(.RAW(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(32)) dB (
    .clk(clk), .reset(reset), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ResultSrcEb0(ResultSrcEb0), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .ForwardAE(bFA), .ForwardBE(bFB), .StallF(bCtl[6]), .StallD(bCtl[5]), .StallE(bCtl[4]),
    .FlushD(bCtl[3]), .FlushE(bCtl[2]), .FlushM(bCtl[1]), .MdBusy(bCtl[0])
`ifdef HAZ_PERF_EN
    , .StallCycles(), .FlushCycles()
`endif
  );

`ifdef HAZ_PERF_EN
  wire [31:0] pStall, pFlush;
  wire [1:0]  sStall, sFlush;
  wire [1:0]  pFA, pFB, sFA, sFB;
  wire [6:0]  pCtl, sCtl;

  dt1_hazunit_mc #(.RAW(5), .LOAD_LAT(2), .MD_LAT(4), .CNT_W(32)) dP (
    .clk(clk), .reset(reset), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ResultSrcEb0(ResultSrcEb0), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .ForwardAE(pFA), .ForwardBE(pFB), .StallF(pCtl[6]), .StallD(pCtl[5]), .StallE(pCtl[4]),
    .FlushD(pCtl[3]), .FlushE(pCtl[2]), .FlushM(pCtl[1]), .MdBusy(pCtl[0]),
    .StallCycles(pStall), .FlushCycles(pFlush)
  );

  dt1_hazunit_mc #(.RAW(5), .LOAD_LAT(2), .MD_LAT(4), .CNT_W(2)) dS (
    .clk(clk), .reset(reset), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ResultSrcEb0(ResultSrcEb0), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
    .ForwardAE(sFA), .ForwardBE(sFB), .StallF(sCtl[6]), .StallD(sCtl[5]), .StallE(sCtl[4]),
    .FlushD(sCtl[3]), .FlushE(sCtl[2]), .FlushM(sCtl[1]), .MdBusy(sCtl[0]),
    .StallCycles(sStall), .FlushCycles(sFlush)
  );
`endif

  task automatic clearIn();
    Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0; Rs1D = '0; Rs2D = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcEb0 = 0; MdStartE = 0; PCSrcE = 0;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLoadUse();
    ResultSrcEb0 = 1; RegWriteE = 1; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  task automatic test_reset();
    clearIn();
    reset = 1;
    setLoadUse();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1;
    #3;
    checks++; if (aCtl !== 7'b0) $display("FAIL reset_ctlA got %b expected %b", aCtl, 7'b0); else passed++;
    checks++; if (bCtl !== 7'b0) $display("FAIL reset_ctlB got %b expected %b", bCtl, 7'b0); else passed++;
    checks++; if (aFA !== 2'b10) $display("FAIL reset_fwdA got %b expected %b", aFA, 2'b10); else passed++;
    tick(); tick();
    clearIn();
    reset = 0;
    tick();
  endtask

  task automatic test_forward();
    clearIn();
    RdM = 5'd5; RdW = 5'd5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5'd5;
    #1;
    checks++; if (aFA !== 2'b10) $display("FAIL fwdA_M got %b expected %b", aFA, 2'b10); else passed++;
    checks++; if (aFB !== 2'b00) $display("FAIL fwdB_none got %b expected %b", aFB, 2'b00); else passed++;
    RegWriteM = 0; #1;
    checks++; if (aFA !== 2'b01) $display("FAIL fwdA_W got %b expected %b", aFA, 2'b01); else passed++;
    Rs1E = 5'd0; RdW = 5'd0; #1;
    checks++; if (aFA !== 2'b00) $display("FAIL fwdA_x0 got %b expected %b", aFA, 2'b00); else passed++;
    Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9; RegWriteM = 1; RegWriteW = 1; #1;
    checks++; if (aFB !== 2'b10) $display("FAIL fwdB_M got %b expected %b", aFB, 2'b10); else passed++;
    RdM = 5'd3; #1;
    checks++; if (aFB !== 2'b01) $display("FAIL fwdB_W got %b expected %b", aFB, 2'b01); else passed++;
    RegWriteW = 0; #1;
    checks++; if (aFB !== 2'b00) $display("FAIL fwdB_off got %b expected %b", aFB, 2'b00); else passed++;
    clearIn();
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] expB;
    clearIn();
    setLoadUse();
    #4;
    checks++; if (aCtl !== 7'b1100100) $display("FAIL lu1_cyc0 got %b expected %b", aCtl, 7'b1100100); else passed++;
    checks++; if (bCtl !== 7'b1100100) $display("FAIL lu3_cyc0 got %b expected %b", bCtl, 7'b1100100); else passed++;
    tick();
    clearIn();
    for (int i = 1; i <= 3; i++) begin
      #4;
      expB = (i < 3) ? 7'b1100101 : 7'b0000000;
      checks++; if (aCtl !== 7'b0) $display("FAIL lu1_cyc%0d got %b expected %b", i, aCtl, 7'b0); else passed++;
      checks++; if (bCtl !== expB) $display("FAIL lu3_cyc%0d got %b expected %b", i, bCtl, expB); else passed++;
      tick();
    end
    ResultSrcEb0 = 1; RegWriteE = 1; RdE = 5'd0; Rs1D = 5'd0;
    #4;
    checks++; if (aCtl !== 7'b0) $display("FAIL lu_x0 got %b expected %b", aCtl, 7'b0); else passed++;
    clearIn();
    tick();
  endtask

  task automatic test_muldiv();
    logic [6:0] exp;
    clearIn();
    MdStartE = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      exp = (i == 0) ? 7'b1110010 : (i < 3) ? 7'b1110011 : 7'b0000000;
      checks++; if (aCtl !== exp) $display("FAIL md_cyc%0d got %b expected %b", i, aCtl, exp); else passed++;
      tick();
    end
    clearIn();
    #4;
    checks++; if (bCtl !== 7'b0) $display("FAIL md_after got %b expected %b", bCtl, 7'b0); else passed++;
    tick();
  endtask

  task automatic test_branch();
    clearIn();
    setLoadUse();
    PCSrcE = 1;
    #4;
    checks++; if (aCtl !== 7'b0001100) $display("FAIL br_ctlA got %b expected %b", aCtl, 7'b0001100); else passed++;
    checks++; if (bCtl !== 7'b0001100) $display("FAIL br_ctlB got %b expected %b", bCtl, 7'b0001100); else passed++;
    tick();
    clearIn();
    #4;
    checks++; if (bCtl !== 7'b0) $display("FAIL br_idle got %b expected %b", bCtl, 7'b0); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_md();
    clearIn();
    MdStartE = 1;
    tick();
    #2;
    checks++; if (aCtl !== 7'b1110011) $display("FAIL rmd_busy got %b expected %b", aCtl, 7'b1110011); else passed++;
    reset = 1;
    #1;
    checks++; if (aCtl !== 7'b0) $display("FAIL rmd_abort got %b expected %b", aCtl, 7'b0); else passed++;
    tick();
    MdStartE = 0;
    reset = 0;
    #4;
    checks++; if (aCtl !== 7'b0) $display("FAIL rmd_post0 got %b expected %b", aCtl, 7'b0); else passed++;
    tick();
    #4;
    checks++; if (aCtl !== 7'b0) $display("FAIL rmd_post1 got %b expected %b", aCtl, 7'b0); else passed++;
    tick();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    clearIn();
    reset = 1; #2; reset = 0;
    tick();
    for (int h = 0; h < 2; h++) begin
      setLoadUse();
      tick();
      clearIn();
      tick(); tick(); tick();
    end
    #4;
    checks++; if (pStall !== 32'd4) $display("FAIL perf_stall got %0d expected %0d", pStall, 4); else passed++;
    checks++; if (pFlush !== 32'd4) $display("FAIL perf_flush got %0d expected %0d", pFlush, 4); else passed++;
    checks++; if (sStall !== 2'd3) $display("FAIL perf_sat_stall got %0d expected %0d", sStall, 3); else passed++;
    tick();
    setLoadUse();
    tick();
    clearIn();
    tick(); tick();
    #4;
    checks++; if (pStall !== 32'd6) $display("FAIL perf_stall3 got %0d expected %0d", pStall, 6); else passed++;
    checks++; if (sStall !== 2'd3) $display("FAIL perf_sat_hold got %0d expected %0d", sStall, 3); else passed++;
    checks++; if (sFlush !== 2'd3) $display("FAIL perf_sat_flush got %0d expected %0d", sFlush, 3); else passed++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    clearIn();
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_muldiv();
    test_branch();
    test_reset_mid_md();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
